// File: rtl/irq_source_latch.sv
// rtl/irq_source_latch.sv - per-line sync, edge/level event latch, mask and APB regs; IRQ_OVERFLOW_EN adds OVERFLOW
module irq_source_latch #(
   parameter int PERIPHERALS = 16,
   parameter int WIDTH       = $clog2(PERIPHERALS),
   parameter int SYNC_STAGES = 2
) (
   input  logic                   pclk,
   input  logic                   prst,
   input  logic                   psel,
   input  logic                   penable,
   input  logic                   pwr_rd_en,
   input  logic [2:0]             paddr,
   input  logic [PERIPHERALS-1:0] pwdata,
   output logic [PERIPHERALS-1:0] prdata,
   output logic                   pready,
   output logic                   perror,
   input  logic [PERIPHERALS-1:0] irq_raw,
   input  logic                   service_valid,
   input  logic [WIDTH-1:0]       service_id,
   input  logic                   service_done,
   output logic [PERIPHERALS-1:0] interrupt_active
);

   localparam logic [2:0] ADDR_MASK     = 3'd0;
   localparam logic [2:0] ADDR_EDGE_SEL = 3'd1;
   localparam logic [2:0] ADDR_PENDING  = 3'd2;
   localparam logic [2:0] ADDR_RAW      = 3'd3;
   localparam logic [2:0] ADDR_FORCE    = 3'd4;
`ifdef IRQ_OVERFLOW_EN
   localparam logic [2:0] ADDR_OVERFLOW = 3'd5;
`endif

   logic [SYNC_STAGES-1:0][PERIPHERALS-1:0] sync_q;
   logic [PERIPHERALS-1:0] sync;
   logic [PERIPHERALS-1:0] sync_d;
   logic [PERIPHERALS-1:0] mask;
   logic [PERIPHERALS-1:0] edge_sel;
   logic [PERIPHERALS-1:0] pending;
   logic [PERIPHERALS-1:0] rise;
   logic [PERIPHERALS-1:0] set_evt;
   logic [PERIPHERALS-1:0] clr_evt;
   logic [PERIPHERALS-1:0] svc_clr;
   logic [PERIPHERALS-1:0] force_set;
   logic [PERIPHERALS-1:0] pend_w1c;
   logic [PERIPHERALS-1:0] rd_mux;
   logic                   illegal;
   logic                   wr_en;

   always_comb begin
      illegal = 1'b0;
      case (paddr)
         ADDR_MASK, ADDR_EDGE_SEL, ADDR_PENDING, ADDR_RAW, ADDR_FORCE: illegal = 1'b0;
`ifdef IRQ_OVERFLOW_EN
         ADDR_OVERFLOW: illegal = 1'b0;
`endif
         default: illegal = 1'b1;
      endcase
   end

   assign wr_en  = psel & penable & pwr_rd_en & ~illegal;
   assign pready = psel & penable & ~prst;
   assign perror = psel & penable & illegal & ~prst;

   always_ff @(posedge pclk or posedge prst) begin
      if (prst) begin
         sync_q <= '0;
         sync_d <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], irq_raw};
         sync_d <= sync_q[SYNC_STAGES-1];
      end
   end

   assign sync = sync_q[SYNC_STAGES-1];
   assign rise = sync & ~sync_d;

   always_comb begin
      svc_clr = '0;
      for (int i = 0; i < PERIPHERALS; i++) begin
         if (service_done && service_valid && (service_id == WIDTH'(i)))
            svc_clr[i] = 1'b1;
      end
   end

   assign force_set = (wr_en && paddr == ADDR_FORCE)   ? pwdata : '0;
   assign pend_w1c  = (wr_en && paddr == ADDR_PENDING) ? pwdata : '0;
   assign set_evt   = (edge_sel & rise) | (~edge_sel & sync) | force_set;
   assign clr_evt   = svc_clr | pend_w1c;

   // Set wins over clear so a level line still high, or an edge landing on a clear, is not lost.
   always_ff @(posedge pclk or posedge prst) begin
      if (prst) begin
         mask             <= '0;
         edge_sel         <= '0;
         pending          <= '0;
         interrupt_active <= '0;
      end else begin
         if (wr_en && paddr == ADDR_MASK)
            mask <= pwdata;
         if (wr_en && paddr == ADDR_EDGE_SEL)
            edge_sel <= pwdata;
         pending          <= (pending & ~clr_evt) | set_evt;
         interrupt_active <= pending & mask;
      end
   end

`ifdef IRQ_OVERFLOW_EN
   logic [PERIPHERALS-1:0] overflow;
   logic [PERIPHERALS-1:0] ovf_set;
   logic [PERIPHERALS-1:0] ovf_w1c;

   assign ovf_set = edge_sel & rise & pending & ~clr_evt;
   assign ovf_w1c = (wr_en && paddr == ADDR_OVERFLOW) ? pwdata : '0;

   always_ff @(posedge pclk or posedge prst) begin
      if (prst)
         overflow <= '0;
      else
         overflow <= (overflow & ~ovf_w1c) | ovf_set;
   end
`endif

   always_comb begin
      rd_mux = '0;
      case (paddr)
         ADDR_MASK:     rd_mux = mask;
         ADDR_EDGE_SEL: rd_mux = edge_sel;
         ADDR_PENDING:  rd_mux = pending;
         ADDR_RAW:      rd_mux = sync;
`ifdef IRQ_OVERFLOW_EN
         ADDR_OVERFLOW: rd_mux = overflow;
`endif
         default:       rd_mux = '0;
      endcase
   end

   assign prdata = (psel && !pwr_rd_en && !prst) ? rd_mux : '0;

endmodule

// File: tb/tb_irq_source_latch.sv
// tb/tb_irq_source_latch.sv - directed bench for irq_source_latch (optionally with IRQ_OVERFLOW_EN)
module tb_irq_source_latch;
   localparam int P = 16;
   localparam int W = 4;

   logic         pclk = 1'b0;
   logic         prst;
   logic         psel;
   logic         penable;
   logic         pwr_rd_en;
   logic [2:0]   paddr;
   logic [P-1:0] pwdata;
   logic [P-1:0] prdata;
   logic         pready;
   logic         perror;
   logic [P-1:0] irq_raw;
   logic         service_valid;
   logic [W-1:0] service_id;
   logic         service_done;
   logic [P-1:0] interrupt_active;

   int checks = 0;
   int errors = 0;

   irq_source_latch #(.PERIPHERALS(P), .WIDTH(W), .SYNC_STAGES(2)) dut (
      .pclk(pclk), .prst(prst), .psel(psel), .penable(penable), .pwr_rd_en(pwr_rd_en),
      .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .perror(perror),
      .irq_raw(irq_raw), .service_valid(service_valid), .service_id(service_id),
      .service_done(service_done), .interrupt_active(interrupt_active)
   );

   always #5 pclk = ~pclk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic apb_write(input logic [2:0] a, input logic [P-1:0] d);
      psel = 1'b1; penable = 1'b0; pwr_rd_en = 1'b1; paddr = a; pwdata = d;
      tick();
      penable = 1'b1;
      tick();
      psel = 1'b0; penable = 1'b0; pwr_rd_en = 1'b0; pwdata = '0;
   endtask

   task automatic apb_read(input logic [2:0] a, output logic [P-1:0] d, output logic rdy, output logic err);
      psel = 1'b1; penable = 1'b0; pwr_rd_en = 1'b0; paddr = a;
      tick();
      penable = 1'b1;
      #1;
      d = prdata; rdy = pready; err = perror;
      tick();
      psel = 1'b0; penable = 1'b0;
   endtask

   task automatic service(input logic [W-1:0] id, input logic valid);
      service_valid = valid; service_id = id; service_done = 1'b1;
      tick();
      service_valid = 1'b0; service_done = 1'b0;
   endtask

   task automatic test_reset();
      logic [P-1:0] d; logic rdy, err;
      prst = 1'b1;
      tick(); tick();
      psel = 1'b1; penable = 1'b1; pwr_rd_en = 1'b0; paddr = 3'd0;
      #1;
      checks++; if (interrupt_active !== 16'h0000) begin errors++; $display("FAIL reset_active: got %h expected %h", interrupt_active, 16'h0000); end
      checks++; if (pready !== 1'b0) begin errors++; $display("FAIL reset_pready: got %b expected 0", pready); end
      checks++; if (prdata !== 16'h0000) begin errors++; $display("FAIL reset_prdata: got %h expected 0000", prdata); end
      psel = 1'b0; penable = 1'b0;
      tick();
      prst = 1'b0;
      tick();
      apb_read(3'd0, d, rdy, err);
      checks++; if (d !== 16'h0000) begin errors++; $display("FAIL reset_mask: got %h expected 0000", d); end
      checks++; if (rdy !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL reset_read_hs: got rdy=%b err=%b expected rdy=1 err=0", rdy, err); end
   endtask

   task automatic test_edge_latency();
      apb_write(3'd0, 16'hFFFF);
      apb_write(3'd1, 16'hFFFF);
      irq_raw[3] = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         if (k < 3) begin
            checks++; if (interrupt_active !== 16'h0000) begin errors++; $display("FAIL edge_early_%0d: got %h expected 0000", k, interrupt_active); end
         end else begin
            checks++; if (interrupt_active !== 16'h0008) begin errors++; $display("FAIL edge_latency: got %h expected 0008", interrupt_active); end
         end
         if (k == 2) irq_raw[3] = 1'b0;
      end
      repeat (4) tick();
      checks++; if (interrupt_active !== 16'h0008) begin errors++; $display("FAIL edge_hold: got %h expected 0008", interrupt_active); end
   endtask

   task automatic test_service();
      service(4'd3, 1'b0);
      tick();
      checks++; if (interrupt_active !== 16'h0008) begin errors++; $display("FAIL service_novalid: got %h expected 0008", interrupt_active); end
      service(4'd3, 1'b1);
      checks++; if (interrupt_active !== 16'h0008) begin errors++; $display("FAIL service_edge_m: got %h expected 0008", interrupt_active); end
      tick();
      checks++; if (interrupt_active !== 16'h0000) begin errors++; $display("FAIL service_clear: got %h expected 0000", interrupt_active); end
   endtask

   task automatic test_level();
      logic [P-1:0] d; logic rdy, err;
      apb_write(3'd1, 16'h0000);
      irq_raw[5] = 1'b1;
      repeat (4) tick();
      checks++; if (interrupt_active !== 16'h0020) begin errors++; $display("FAIL level_active: got %h expected 0020", interrupt_active); end
      apb_read(3'd3, d, rdy, err);
      checks++; if (d !== 16'h0020) begin errors++; $display("FAIL level_raw: got %h expected 0020", d); end
      service(4'd5, 1'b1);
      for (int k = 0; k < 3; k++) begin
         checks++; if (interrupt_active !== 16'h0020) begin errors++; $display("FAIL level_repend_%0d: got %h expected 0020", k, interrupt_active); end
         tick();
      end
      irq_raw[5] = 1'b0;
      repeat (3) tick();
      service(4'd5, 1'b1);
      tick();
      checks++; if (interrupt_active !== 16'h0000) begin errors++; $display("FAIL level_clear: got %h expected 0000", interrupt_active); end
   endtask

   task automatic test_mask();
      logic [P-1:0] d; logic rdy, err;
      apb_write(3'd0, 16'h0000);
      apb_write(3'd1, 16'hFFFF);
      irq_raw[7] = 1'b1;
      repeat (3) tick();
      irq_raw[7] = 1'b0;
      repeat (3) tick();
      checks++; if (interrupt_active !== 16'h0000) begin errors++; $display("FAIL mask_gated: got %h expected 0000", interrupt_active); end
      apb_read(3'd2, d, rdy, err);
      checks++; if (d !== 16'h0080) begin errors++; $display("FAIL mask_pending: got %h expected 0080", d); end
      apb_write(3'd0, 16'h0080);
      tick();
      checks++; if (interrupt_active !== 16'h0080) begin errors++; $display("FAIL mask_unmask: got %h expected 0080", interrupt_active); end
      apb_write(3'd2, 16'h0080);
      tick();
      checks++; if (interrupt_active !== 16'h0000) begin errors++; $display("FAIL mask_w1c: got %h expected 0000", interrupt_active); end
      apb_write(3'd0, 16'h0081);
      apb_write(3'd4, 16'h0001);
      tick();
      checks++; if (interrupt_active !== 16'h0001) begin errors++; $display("FAIL mask_force: got %h expected 0001", interrupt_active); end
      apb_read(3'd4, d, rdy, err);
      checks++; if (d !== 16'h0000) begin errors++; $display("FAIL force_read: got %h expected 0000", d); end
      apb_write(3'd2, 16'h0001);
   endtask

   task automatic test_back_to_back();
      apb_write(3'd0, 16'hFFFF);
      apb_write(3'd4, 16'h0200);
      irq_raw[9] = 1'b1;
      tick();
      apb_write(3'd2, 16'h0200);
      tick();
      checks++; if (interrupt_active !== 16'h0200) begin errors++; $display("FAIL b2b_edge_kept: got %h expected 0200", interrupt_active); end
      irq_raw[9] = 1'b0;
      service(4'd9, 1'b1);
      tick();
      checks++; if (interrupt_active !== 16'h0000) begin errors++; $display("FAIL b2b_clear: got %h expected 0000", interrupt_active); end
   endtask

   task automatic test_illegal();
      logic [P-1:0] d; logic rdy, err;
      apb_read(3'd6, d, rdy, err);
      checks++; if (rdy !== 1'b1 || err !== 1'b1 || d !== 16'h0000) begin errors++; $display("FAIL illegal_read6: got rdy=%b err=%b d=%h expected rdy=1 err=1 d=0000", rdy, err, d); end
      apb_write(3'd7, 16'h1234);
      tick();
      apb_read(3'd0, d, rdy, err);
      checks++; if (d !== 16'hFFFF) begin errors++; $display("FAIL illegal_mask: got %h expected FFFF", d); end
      apb_read(3'd1, d, rdy, err);
      checks++; if (d !== 16'hFFFF) begin errors++; $display("FAIL illegal_edge_sel: got %h expected FFFF", d); end
      apb_read(3'd2, d, rdy, err);
      checks++; if (d !== 16'h0000) begin errors++; $display("FAIL illegal_pending: got %h expected 0000", d); end
      apb_read(3'd5, d, rdy, err);
`ifdef IRQ_OVERFLOW_EN
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL addr5_legal: got err=%b expected 0", err); end
`else
      checks++; if (err !== 1'b1 || d !== 16'h0000) begin errors++; $display("FAIL addr5_illegal: got err=%b d=%h expected err=1 d=0000", err, d); end
`endif
   endtask

`ifdef IRQ_OVERFLOW_EN
   task automatic test_overflow();
      logic [P-1:0] d; logic rdy, err;
      for (int k = 0; k < 2; k++) begin
         irq_raw[2] = 1'b1;
         repeat (3) tick();
         irq_raw[2] = 1'b0;
         repeat (3) tick();
      end
      apb_read(3'd5, d, rdy, err);
      checks++; if (d !== 16'h0004) begin errors++; $display("FAIL overflow_set: got %h expected 0004", d); end
      apb_write(3'd5, 16'h0004);
      apb_read(3'd5, d, rdy, err);
      checks++; if (d !== 16'h0000) begin errors++; $display("FAIL overflow_w1c: got %h expected 0000", d); end
      service(4'd2, 1'b1);
      tick();
   endtask
`endif

   task automatic test_async_reset();
      logic [P-1:0] d; logic rdy, err;
      apb_write(3'd4, 16'hFFFF);
      tick(); tick();
      checks++; if (interrupt_active !== 16'hFFFF) begin errors++; $display("FAIL areset_pre: got %h expected FFFF", interrupt_active); end
      @(negedge pclk);
      prst = 1'b1;
      #1;
      checks++; if (interrupt_active !== 16'h0000) begin errors++; $display("FAIL areset_immediate: got %h expected 0000", interrupt_active); end
      tick();
      prst = 1'b0;
      tick();
      apb_read(3'd0, d, rdy, err);
      checks++; if (d !== 16'h0000) begin errors++; $display("FAIL areset_mask: got %h expected 0000", d); end
      apb_read(3'd2, d, rdy, err);
      checks++; if (d !== 16'h0000) begin errors++; $display("FAIL areset_pending: got %h expected 0000", d); end
   endtask

   initial begin
      prst = 1'b1; psel = 1'b0; penable = 1'b0; pwr_rd_en = 1'b0; paddr = '0; pwdata = '0;
      irq_raw = '0; service_valid = 1'b0; service_id = '0; service_done = 1'b0;
      test_reset();
      test_edge_latency();
      test_service();
      test_level();
      test_mask();
      test_back_to_back();
      test_illegal();
`ifdef IRQ_OVERFLOW_EN
      test_overflow();
`endif
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
